// File: rtl/jk_excite_drv.sv
// Computes JK excitation that moves the owned bank to each accepted target, then checks it.
// Latency: q reaches target 1 edge after accept, done 2 edges after; tgt_ready only in IDLE (1 target per 3 cycles).
module jk_excite_drv #(
   parameter int WIDTH       = 4,
   parameter int CNT_W       = 8,
   parameter bit TOGGLE_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             done,
   output logic             mismatch,
   output logic [CNT_W-1:0] toggle_cnt
);

   localparam int PC_W  = $clog2(WIDTH + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

   typedef enum logic [1:0] {IDLE, EXCITE, CHECK} state_t;

   state_t           state, state_next;
   logic             accept;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] chg;
   logic [WIDTH-1:0] j_next;
   logic [WIDTH-1:0] k_next;
   logic [WIDTH-1:0] diff;
   logic [PC_W-1:0]  pop;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_next;

   assign qbar = ~q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      tgt_ready  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            tgt_ready = 1'b1;
            accept    = tgt_valid;
            if (tgt_valid) state_next = EXCITE;
         end
         EXCITE:  state_next = CHECK;
         CHECK:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Changing bits get set/reset excitation, or J=K=1 when toggling is preferred.
   always_comb begin
      chg    = q ^ tgt_data;
      j_next = TOGGLE_MODE ? chg : (chg & tgt_data);
      k_next = TOGGLE_MODE ? chg : (chg & q);
   end

   // Bits about to flip are counted against the pre-update q.
   always_comb begin
      diff = q ^ tgt_q;
      pop  = '0;
      for (int i = 0; i < WIDTH; i++) pop = pop + PC_W'(diff[i]);
      sum      = SUM_W'(toggle_cnt) + SUM_W'(pop);
      cnt_next = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q          <= '0;
         tgt_q      <= '0;
         j_out      <= '0;
         k_out      <= '0;
         done       <= 1'b0;
         mismatch   <= 1'b0;
         toggle_cnt <= '0;
      end else begin
         q    <= (j_out & ~q) | (~k_out & q);
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  tgt_q    <= tgt_data;
                  j_out    <= j_next;
                  k_out    <= k_next;
                  mismatch <= 1'b0;
               end
            end
            EXCITE: begin
               toggle_cnt <= cnt_next;
               j_out      <= '0;
               k_out      <= '0;
            end
            CHECK: begin
               done     <= 1'b1;
               mismatch <= (q != tgt_q);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_excite_drv.sv
// Bench for jk_excite_drv: default instance with a done-driven scoreboard, plus a toggle-mode 2-bit-counter instance.
module tb_jk_excite_drv;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tgt_valid, tgt_ready, done, mismatch;
   logic [3:0] tgt_data, j_out, k_out, q, qbar;
   logic [7:0] toggle_cnt;

   logic       x_valid, x_ready, x_done, x_mismatch;
   logic [3:0] x_data, x_j, x_k, x_qo, x_qbar;
   logic [1:0] x_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] q;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [3:0] m_q;
   logic [7:0] m_cnt;
   logic [3:0] x_q;
   logic [1:0] x_m_cnt;

   always #5 clk = ~clk;

   jk_excite_drv dut (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
      .tgt_data(tgt_data), .j_out(j_out), .k_out(k_out), .q(q), .qbar(qbar),
      .done(done), .mismatch(mismatch), .toggle_cnt(toggle_cnt)
   );

   jk_excite_drv #(.WIDTH(4), .CNT_W(2), .TOGGLE_MODE(1'b1)) dut_x (
      .clk(clk), .rst_n(rst_n), .tgt_valid(x_valid), .tgt_ready(x_ready),
      .tgt_data(x_data), .j_out(x_j), .k_out(x_k), .q(x_qo), .qbar(x_qbar),
      .done(x_done), .mismatch(x_mismatch), .toggle_cnt(x_cnt)
   );

   function automatic logic [7:0] sat8(input logic [7:0] c, input int n);
      int s;
      s = int'(c) + n;
      return (s > 255) ? 8'hFF : 8'(s);
   endfunction

   function automatic logic [1:0] sat2(input logic [1:0] c, input int n);
      int s;
      s = int'(c) + n;
      return (s > 3) ? 2'd3 : 2'(s);
   endfunction

   task automatic push_exp(input logic [3:0] d);
      m_cnt = sat8(m_cnt, $countones(m_q ^ d));
      m_q   = d;
      sb.push_back('{q: d, cnt: m_cnt});
   endtask

   // Scoreboard: every done pulse retires the oldest accepted target.
   always @(negedge clk) begin
      if (rst_n && done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done q=%h cnt=%0d", q, toggle_cnt);
         end else begin
            mon_e = sb.pop_front();
            if (q !== mon_e.q || toggle_cnt !== mon_e.cnt || mismatch !== 1'b0) begin
               errors++;
               $display("FAIL done_result q=%h exp %h cnt=%0d exp %0d mismatch=%b exp 0",
                        q, mon_e.q, toggle_cnt, mon_e.cnt, mismatch);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; tgt_valid = 1'b0; tgt_data = '0; x_valid = 1'b0; x_data = '0;
      m_q = '0; m_cnt = '0; x_q = '0; x_m_cnt = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (q !== 4'h0 || j_out !== 4'h0) begin
         errors++;
         $display("FAIL reset_hold q=%h j=%h exp 0 0", q, j_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({q, qbar, tgt_ready, j_out, k_out, toggle_cnt, done, mismatch} !==
          {4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state q=%h qbar=%h rdy=%b j=%h k=%h cnt=%0d done=%b mm=%b",
                  q, qbar, tgt_ready, j_out, k_out, toggle_cnt, done, mismatch);
      end
   endtask

   task automatic send_main(input logic [3:0] d);
      logic [3:0] ej, ek;
      int t;
      @(negedge clk);
      t = 0;
      while (!tgt_ready && t < 10) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (tgt_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_timeout rdy=%b exp 1", tgt_ready);
      end
      ej = ~m_q & d;
      ek = m_q & ~d;
      tgt_valid = 1'b1;
      tgt_data  = d;
      push_exp(d);
      @(negedge clk);
      tgt_valid = 1'b0;
      tgt_data  = ~d;
      checks++;
      if ({j_out, k_out, tgt_ready, done} !== {ej, ek, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL excite j=%b k=%b rdy=%b done=%b exp j=%b k=%b rdy=0 done=0",
                  j_out, k_out, tgt_ready, done, ej, ek);
      end
      @(negedge clk);
      checks++;
      if ({q, qbar, toggle_cnt, j_out, k_out} !== {d, ~d, m_cnt, 8'h00}) begin
         errors++;
         $display("FAIL q_update q=%b qbar=%b cnt=%0d j=%b k=%b exp q=%b cnt=%0d jk=0",
                  q, qbar, toggle_cnt, j_out, k_out, d, m_cnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse done=%b exp 1", done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width done=%b exp 0", done);
      end
   endtask

   task automatic test_basic();
      send_main(4'b1010);
      send_main(4'b0110);
      checks++;
      if (toggle_cnt !== 8'd4) begin
         errors++;
         $display("FAIL basic_count cnt=%0d exp 4", toggle_cnt);
      end
   endtask

   task automatic test_no_change();
      send_main(4'b0110);
      checks++;
      if (toggle_cnt !== 8'd4 || q !== 4'b0110) begin
         errors++;
         $display("FAIL no_change cnt=%0d q=%b exp 4 0110", toggle_cnt, q);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] d;
      logic       exp_rdy;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         exp_rdy = (i % 3 == 0);
         checks++;
         if (tgt_ready !== exp_rdy) begin
            errors++;
            $display("FAIL b2b_ready cycle=%0d rdy=%b exp %b", i, tgt_ready, exp_rdy);
         end
         d = 4'($urandom);
         tgt_valid = 1'b1;
         tgt_data  = d;
         if (exp_rdy) push_exp(d);
      end
      @(negedge clk);
      tgt_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain pending=%0d exp 0", sb.size());
      end
   endtask

   task automatic x_send(input logic [3:0] d);
      logic [3:0] ejk;
      int t;
      @(negedge clk);
      t = 0;
      while (!x_ready && t < 10) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (x_ready !== 1'b1) begin
         errors++;
         $display("FAIL x_ready_timeout rdy=%b exp 1", x_ready);
      end
      ejk     = x_q ^ d;
      x_m_cnt = sat2(x_m_cnt, $countones(ejk));
      x_q     = d;
      x_valid = 1'b1;
      x_data  = d;
      @(negedge clk);
      x_valid = 1'b0;
      x_data  = ~d;
      checks++;
      if ({x_j, x_k} !== {ejk, ejk}) begin
         errors++;
         $display("FAIL x_excite j=%b k=%b exp %b %b", x_j, x_k, ejk, ejk);
      end
      @(negedge clk);
      checks++;
      if ({x_qo, x_qbar, x_cnt} !== {d, ~d, x_m_cnt}) begin
         errors++;
         $display("FAIL x_update q=%b qbar=%b cnt=%0d exp q=%b cnt=%0d", x_qo, x_qbar, x_cnt, d, x_m_cnt);
      end
      @(negedge clk);
      checks++;
      if ({x_done, x_mismatch} !== 2'b10) begin
         errors++;
         $display("FAIL x_done done=%b mm=%b exp 1 0", x_done, x_mismatch);
      end
   endtask

   task automatic test_toggle_saturate();
      x_send(4'b1010);
      x_send(4'b0110);
      x_send(4'b1001);
      checks++;
      if (x_cnt !== 2'd3) begin
         errors++;
         $display("FAIL x_saturate cnt=%0d exp 3", x_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      int done_seen;
      send_main(4'b1001);
      @(negedge clk);
      t = 0;
      while (!tgt_ready && t < 10) begin
         @(negedge clk);
         t++;
      end
      tgt_valid = 1'b1;
      tgt_data  = 4'b0110;
      @(negedge clk);
      tgt_valid = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      m_q = '0; m_cnt = '0; x_q = '0; x_m_cnt = '0;
      #1;
      checks++;
      if ({q, qbar, j_out, k_out, toggle_cnt, done, tgt_ready} !==
          {4'h0, 4'hF, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset q=%h qbar=%h j=%h k=%h cnt=%0d done=%b rdy=%b",
                  q, qbar, j_out, k_out, toggle_cnt, done, tgt_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      checks++;
      if (done_seen != 0 || q !== 4'h0) begin
         errors++;
         $display("FAIL mid_reset_drop done_seen=%0d q=%h exp 0 0", done_seen, q);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_no_change();
      test_back_to_back();
      test_toggle_saturate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
